// File: rtl/ufm_page_writer.sv
// ufm_page_writer
//   Programs one 16-byte MachXO2 UFM page through the EFB Wishbone config port.
//   Acts as a self-contained WB master. A job enables config mode, polls busy,
//   optionally erases the UFM, sets the page address, programs the page, polls
//   again, then disables config mode and sends bypass. The 16 page bytes come
//   from the user over a valid/ready handshake.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start/erase/page_addr   job request; erase and page latched on accepted start
//   wr_data/wr_valid/wr_ready   page byte handshake (lowest UFM address first)
//   ready              idle, start accepted
//   done               1-cycle pulse at job end
//   error              poll timeout or UFM fail in the last job
//   efb_*              Wishbone master port to the EFB
module ufm_page_writer #(
    parameter logic [15:0] POLL_MAX = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        erase,
    input  logic [10:0] page_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic        efb_cyc_o,
    output logic        efb_stb_o,
    output logic        efb_we_o,
    output logic [7:0]  efb_adr_o,
    output logic [7:0]  efb_dat_o,
    input  logic [7:0]  efb_dat_i,
    input  logic        efb_ack_i
);

    typedef enum logic [3:0] {
        J_IDLE, J_EN_CFG, J_POLL_A, J_ERASE, J_POLL_E,
        J_SET_ADDR, J_PROGRAM, J_POLL_P, J_DISABLE, J_BYPASS
    } job_t;

    // Position inside one config frame.
    typedef enum logic [2:0] {P_OPEN, P_CMD, P_OPR, P_DATA, P_CLOSE} phase_t;

    localparam logic [7:0] ADR_CFGCR = 8'h70;
    localparam logic [7:0] ADR_TXDR  = 8'h71;
    localparam logic [7:0] ADR_RXDR  = 8'h73;

    function automatic logic is_poll(input job_t j);
        return (j == J_POLL_A) || (j == J_POLL_E) || (j == J_POLL_P);
    endfunction

    function automatic logic [7:0] cmd_of(input job_t j);
        case (j)
            J_EN_CFG:   return 8'h74;
            J_ERASE:    return 8'hCB;
            J_POLL_A,
            J_POLL_E,
            J_POLL_P:   return 8'h3C;
            J_SET_ADDR: return 8'hB4;
            J_PROGRAM:  return 8'hC9;
            J_DISABLE:  return 8'h26;
            default:    return 8'hFF;
        endcase
    endfunction

    function automatic logic [4:0] n_opr(input job_t j);
        case (j)
            J_DISABLE: return 5'd2;
            J_BYPASS:  return 5'd0;
            default:   return 5'd3;
        endcase
    endfunction

    function automatic logic [4:0] n_data(input job_t j);
        case (j)
            J_POLL_A, J_POLL_E, J_POLL_P, J_SET_ADDR: return 5'd4;
            J_PROGRAM: return 5'd16;
            default:   return 5'd0;
        endcase
    endfunction

    function automatic logic [7:0] opr_of(input job_t j, input logic [1:0] idx);
        if ((j == J_EN_CFG) && (idx == 2'd0)) begin
            return 8'h08;
        end else if ((j == J_PROGRAM) && (idx == 2'd2)) begin
            return 8'h01;
        end else begin
            return 8'h00;
        end
    endfunction

    function automatic logic [7:0] addr_byte(input logic [10:0] pg, input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h40;
            2'd1:    return 8'h00;
            2'd2:    return {5'b00000, pg[10:8]};
            default: return pg[7:0];
        endcase
    endfunction

    job_t        job_q, job_d;
    phase_t      phase_q, phase_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        erase_q, erase_d;
    logic [10:0] page_q, page_d;
    logic        busy_q, busy_d, fail_q, fail_d;
    logic        ready_q, ready_d, done_q, done_d, error_q, error_d;
    logic        wr_ready_q, wr_ready_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [7:0]  adr_q, adr_d, dat_q, dat_d;

    // Only busy and fail are meaningful in the status byte.
    logic status_unused_s;
    assign status_unused_s = ^{efb_dat_i[7:6], efb_dat_i[3:0]};

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_q      <= J_IDLE;
            phase_q    <= P_OPEN;
            cnt_q      <= 5'd0;
            poll_cnt_q <= 16'd0;
            erase_q    <= 1'b0;
            page_q     <= 11'd0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 8'h00;
            dat_q      <= 8'h00;
        end else begin
            job_q      <= job_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            poll_cnt_q <= poll_cnt_d;
            erase_q    <= erase_d;
            page_q     <= page_d;
            busy_q     <= busy_d;
            fail_q     <= fail_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
            wr_ready_q <= wr_ready_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    // Job sequencing, frame stepping and next bus access.
    always_comb begin
        job_d      = job_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        poll_cnt_d = poll_cnt_q;
        erase_d    = erase_q;
        page_d     = page_q;
        busy_d     = busy_q;
        fail_d     = fail_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        error_d    = error_q;
        wr_ready_d = wr_ready_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;

        if (job_q == J_IDLE) begin
            // The done cycle already shows ready; a start there is not taken.
            if (start && ready_q && !done_q) begin
                job_d   = J_EN_CFG;
                phase_d = P_OPEN;
                cnt_d   = 5'd0;
                erase_d = erase;
                page_d  = page_addr;
                ready_d = 1'b0;
                error_d = 1'b0;
            end else begin
                job_d = J_IDLE;
            end
        end else if (cyc_q) begin
            // Access in flight: step the frame on ack, leaving one idle cycle after it.
            if (efb_ack_i) begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                we_d  = 1'b0;
                case (phase_q)
                    P_OPEN: begin
                        phase_d = P_CMD;
                    end
                    P_CMD: begin
                        cnt_d = 5'd0;
                        if (n_opr(job_q) != 5'd0) begin
                            phase_d = P_OPR;
                        end else if (n_data(job_q) != 5'd0) begin
                            phase_d = P_DATA;
                        end else begin
                            phase_d = P_CLOSE;
                        end
                    end
                    P_OPR: begin
                        if (cnt_q == n_opr(job_q) - 5'd1) begin
                            cnt_d   = 5'd0;
                            phase_d = (n_data(job_q) != 5'd0) ? P_DATA : P_CLOSE;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    P_DATA: begin
                        if (is_poll(job_q) && (cnt_q == 5'd2)) begin
                            busy_d = efb_dat_i[4];
                            fail_d = efb_dat_i[5];
                        end else begin
                            busy_d = busy_q;
                        end
                        if (cnt_q == n_data(job_q) - 5'd1) begin
                            cnt_d   = 5'd0;
                            phase_d = P_CLOSE;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    P_CLOSE: begin
                        phase_d = P_OPEN;
                        cnt_d   = 5'd0;
                        case (job_q)
                            J_EN_CFG: begin
                                job_d      = J_POLL_A;
                                poll_cnt_d = 16'd0;
                            end
                            J_POLL_A, J_POLL_E, J_POLL_P: begin
                                if (fail_q) begin
                                    error_d = 1'b1;
                                    job_d   = J_DISABLE;
                                end else if (busy_q) begin
                                    if (poll_cnt_q + 16'd1 >= POLL_MAX) begin
                                        error_d    = 1'b1;
                                        job_d      = J_DISABLE;
                                        poll_cnt_d = 16'd0;
                                    end else begin
                                        poll_cnt_d = poll_cnt_q + 16'd1;
                                    end
                                end else begin
                                    poll_cnt_d = 16'd0;
                                    case (job_q)
                                        J_POLL_A: job_d = erase_q ? J_ERASE : J_SET_ADDR;
                                        J_POLL_E: job_d = J_SET_ADDR;
                                        default:  job_d = J_DISABLE;
                                    endcase
                                end
                            end
                            J_ERASE: begin
                                job_d      = J_POLL_E;
                                poll_cnt_d = 16'd0;
                            end
                            J_SET_ADDR: job_d = J_PROGRAM;
                            J_PROGRAM: begin
                                job_d      = J_POLL_P;
                                poll_cnt_d = 16'd0;
                            end
                            J_DISABLE: job_d = J_BYPASS;
                            J_BYPASS: begin
                                job_d   = J_IDLE;
                                done_d  = 1'b1;
                                ready_d = 1'b1;
                            end
                            default: begin
                                job_d   = J_IDLE;
                                ready_d = 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        phase_d = P_OPEN;
                    end
                endcase
            end else begin
                cyc_d = 1'b1;
            end
        end else if (wr_ready_q) begin
            // Waiting on the user; the accepted byte goes out on the next cycle.
            if (wr_valid) begin
                wr_ready_d = 1'b0;
                cyc_d      = 1'b1;
                stb_d      = 1'b1;
                we_d       = 1'b1;
                adr_d      = ADR_TXDR;
                dat_d      = wr_data;
            end else begin
                wr_ready_d = 1'b1;
            end
        end else if ((job_q == J_PROGRAM) && (phase_q == P_DATA)) begin
            wr_ready_d = 1'b1;
        end else begin
            // Idle gap: open the next access of the current frame.
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = 1'b1;
            case (phase_q)
                P_OPEN: begin
                    adr_d = ADR_CFGCR;
                    dat_d = 8'h80;
                end
                P_CMD: begin
                    adr_d = ADR_TXDR;
                    dat_d = cmd_of(job_q);
                end
                P_OPR: begin
                    adr_d = ADR_TXDR;
                    dat_d = opr_of(job_q, cnt_q[1:0]);
                end
                P_DATA: begin
                    if (is_poll(job_q)) begin
                        we_d  = 1'b0;
                        adr_d = ADR_RXDR;
                        dat_d = 8'h00;
                    end else begin
                        adr_d = ADR_TXDR;
                        dat_d = addr_byte(page_q, cnt_q[1:0]);
                    end
                end
                P_CLOSE: begin
                    adr_d = ADR_CFGCR;
                    dat_d = 8'h00;
                end
                default: begin
                    adr_d = ADR_CFGCR;
                    dat_d = 8'h00;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign error     = error_q;
    assign efb_cyc_o = cyc_q;
    assign efb_stb_o = stb_q;
    assign efb_we_o  = we_q;
    assign efb_adr_o = adr_q;
    assign efb_dat_o = dat_q;

endmodule

// File: tb/tb_ufm_page_writer.sv
// Bench for ufm_page_writer: an EFB slave model logs every WB access and
// compares it against a queue of expected accesses; a done monitor compares
// the error flag against a queue of expected job results.
module tb_ufm_page_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        erase = 1'b0;
    logic [10:0] page_addr = 11'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready, ready, done, error;
    logic        efb_cyc_o, efb_stb_o, efb_we_o;
    logic [7:0]  efb_adr_o, efb_dat_o;
    logic [7:0]  efb_dat_i = 8'h00;
    logic        efb_ack_i = 1'b0;

    always #5 clk = ~clk;

    ufm_page_writer #(.POLL_MAX(16'd4)) dut (
        .clk(clk), .rst(rst), .start(start), .erase(erase), .page_addr(page_addr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ready(ready), .done(done), .error(error),
        .efb_cyc_o(efb_cyc_o), .efb_stb_o(efb_stb_o), .efb_we_o(efb_we_o),
        .efb_adr_o(efb_adr_o), .efb_dat_o(efb_dat_o),
        .efb_dat_i(efb_dat_i), .efb_ack_i(efb_ack_i)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] exp_q[$];
    logic        exp_err_q[$];
    int          jobs_done = 0;
    int          busy_a_left = 0;
    int          busy_p_left = 0;
    logic        fail_e = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_acc(input logic we, input logic [7:0] adr, input logic [7:0] dat);
        exp_q.push_back({we, adr, dat});
    endtask

    task automatic push_hdr(input logic [7:0] cmd, input int nopr,
                            input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2);
        push_acc(1'b1, 8'h70, 8'h80);
        push_acc(1'b1, 8'h71, cmd);
        if (nopr > 0) push_acc(1'b1, 8'h71, o0);
        if (nopr > 1) push_acc(1'b1, 8'h71, o1);
        if (nopr > 2) push_acc(1'b1, 8'h71, o2);
    endtask

    task automatic push_close();
        push_acc(1'b1, 8'h70, 8'h00);
    endtask

    task automatic push_poll();
        push_hdr(8'h3C, 3, 8'h00, 8'h00, 8'h00);
        repeat (4) push_acc(1'b0, 8'h73, 8'h00);
        push_close();
    endtask

    task automatic push_en();
        push_hdr(8'h74, 3, 8'h08, 8'h00, 8'h00);
        push_close();
    endtask

    task automatic push_tail();
        push_hdr(8'h26, 2, 8'h00, 8'h00, 8'h00);
        push_close();
        push_hdr(8'hFF, 0, 8'h00, 8'h00, 8'h00);
        push_close();
    endtask

    task automatic push_addr(input logic [7:0] hi, input logic [7:0] lo);
        push_hdr(8'hB4, 3, 8'h00, 8'h00, 8'h00);
        push_acc(1'b1, 8'h71, 8'h40);
        push_acc(1'b1, 8'h71, 8'h00);
        push_acc(1'b1, 8'h71, hi);
        push_acc(1'b1, 8'h71, lo);
        push_close();
    endtask

    task automatic push_prog(input logic [7:0] base);
        logic [7:0] b;
        push_hdr(8'hC9, 3, 8'h00, 8'h00, 8'h01);
        b = base;
        for (int i = 0; i < 16; i++) begin
            push_acc(1'b1, 8'h71, b);
            b = b + 8'h01;
        end
        push_close();
    endtask

    // Page/erase are scrambled after the start to show they were latched.
    task automatic start_job(input logic [10:0] pg, input logic er);
        @(negedge clk);
        page_addr = pg;
        erase     = er;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        page_addr = ~pg;
        erase     = ~er;
        chk("started_ready_error", {ready, error}, 2'b00);
    endtask

    task automatic feed(input logic [7:0] base, input int count, input int stall_idx);
        logic [7:0] b;
        int t;
        b = base;
        for (int i = 0; i < count; i++) begin
            if (i == stall_idx) begin
                t = 0;
                while (!wr_ready && t < 500) begin @(negedge clk); t++; end
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_cyc_wr_ready", {efb_cyc_o, wr_ready}, 2'b01);
                end
            end
            wr_data  = b;
            wr_valid = 1'b1;
            t = 0;
            while (!wr_ready && t < 500) begin @(negedge clk); t++; end
            chk("wr_ready_wait", (t < 500) ? 1 : 0, 1);
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
            b = b + 8'h01;
        end
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (jobs_done < target && t < 3000) begin @(negedge clk); t++; end
        chk("done_count", jobs_done, target);
        chk("wb_queue_drained", exp_q.size(), 0);
    endtask

    // EFB slave: acks each access one cycle late, checks it, answers polls.
    initial begin : wb_slave
        logic [7:0]  last_op;
        int          rd_idx;
        logic        cmd_seen;
        logic [16:0] act;
        logic [16:0] exp;
        last_op  = 8'h00;
        rd_idx   = 0;
        cmd_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (efb_cyc_o && !efb_ack_i) begin
                act = {efb_we_o, efb_adr_o, (efb_we_o ? efb_dat_o : 8'h00)};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wb_unexpected: got we/adr/dat %h, required no access", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp || efb_stb_o !== 1'b1) begin
                        n_bad++;
                        $display("FAIL wb_access: got we/adr/dat %h stb %b, required %h stb 1",
                                 act, efb_stb_o, exp);
                    end
                end
                efb_dat_i = 8'h00;
                if (efb_we_o && efb_adr_o == 8'h70 && efb_dat_o == 8'h80) begin
                    rd_idx   = 0;
                    cmd_seen = 1'b0;
                end else if (efb_we_o && efb_adr_o == 8'h71 && !cmd_seen) begin
                    cmd_seen = 1'b1;
                    if (efb_dat_o == 8'h74 || efb_dat_o == 8'hCB || efb_dat_o == 8'hC9)
                        last_op = efb_dat_o;
                end else if (!efb_we_o && efb_adr_o == 8'h73) begin
                    if (rd_idx == 2) begin
                        case (last_op)
                            8'h74: if (busy_a_left > 0) begin efb_dat_i = 8'h10; busy_a_left--; end
                            8'hCB: if (fail_e) efb_dat_i = 8'h20;
                            8'hC9: if (busy_p_left > 0) begin efb_dat_i = 8'h10; busy_p_left--; end
                            default: efb_dat_i = 8'h00;
                        endcase
                    end
                    rd_idx++;
                end
                efb_ack_i = 1'b1;
            end else begin
                efb_ack_i = 1'b0;
            end
        end
    end

    // Done monitor: each done pulse is checked against the next expected result.
    initial begin : done_mon
        logic e;
        forever begin
            @(negedge clk);
            if (done) begin
                n_cmp++;
                if (exp_err_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL done_unexpected: got done=1, required no done");
                end else begin
                    e = exp_err_q.pop_front();
                    if ({error, ready} !== {e, 1'b1}) begin
                        n_bad++;
                        $display("FAIL done_status: got error=%b ready=%b, required error=%b ready=1",
                                 error, ready, e);
                    end
                end
                jobs_done++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t;
        // reset state: ready,done,error,wr_ready,cyc,stb,we,adr,dat
        #12;
        chk("reset_state", {ready, done, error, wr_ready, efb_cyc_o, efb_stb_o, efb_we_o,
                            efb_adr_o, efb_dat_o}, {7'b1000000, 16'h0000});
        @(negedge clk);
        rst = 1'b0;

        // Job 1: page 0x123, no erase, stall before byte 7.
        push_en(); push_poll(); push_addr(8'h01, 8'h23); push_prog(8'h00); push_poll(); push_tail();
        exp_err_q.push_back(1'b0);
        start_job(11'h123, 1'b0);
        feed(8'h00, 16, 7);
        wait_done(1);

        // Job 2: page 0x7FF, busy for three POLL_P polls -> four POLL_P frames.
        busy_p_left = 3;
        push_en(); push_poll(); push_addr(8'h07, 8'hFF); push_prog(8'hA0);
        repeat (4) push_poll();
        push_tail();
        exp_err_q.push_back(1'b0);
        start_job(11'h7FF, 1'b0);
        feed(8'hA0, 16, -1);
        wait_done(2);
        chk("busy_p_consumed", busy_p_left, 0);

        // Job 3: busy stuck on POLL_A, POLL_MAX=4 -> timeout, no program.
        busy_a_left = 1000;
        push_en();
        repeat (4) push_poll();
        push_tail();
        exp_err_q.push_back(1'b1);
        start_job(11'h055, 1'b0);
        wait_done(3);
        busy_a_left = 0;
        repeat (3) @(negedge clk);
        chk("error_held", {error, ready}, 2'b11);

        // Job 4: erase with fail bit on POLL_E -> no SET_ADDR/PROGRAM; start clears error.
        fail_e = 1'b1;
        push_en(); push_poll();
        push_hdr(8'hCB, 3, 8'h00, 8'h00, 8'h00); push_close();
        push_poll(); push_tail();
        exp_err_q.push_back(1'b1);
        start_job(11'h200, 1'b1);
        wait_done(4);
        fail_e = 1'b0;

        // Job 5: reset while waiting for byte 9 of PROGRAM.
        push_en(); push_poll(); push_addr(8'h00, 8'h42); push_prog(8'h50); push_poll(); push_tail();
        exp_err_q.push_back(1'b0);
        start_job(11'h042, 1'b0);
        feed(8'h50, 9, -1);
        t = 0;
        while (!wr_ready && t < 500) begin @(negedge clk); t++; end
        chk("wr_ready_before_rst", wr_ready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_midjob_state", {ready, done, error, wr_ready, efb_cyc_o, efb_stb_o, efb_we_o,
                                 efb_adr_o, efb_dat_o}, {7'b1000000, 16'h0000});
        chk("accesses_left_at_rst", exp_q.size(), 26);
        exp_q.delete();
        exp_err_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Job 6: normal job after reset, page 0x3C0.
        push_en(); push_poll(); push_addr(8'h03, 8'hC0); push_prog(8'h30); push_poll(); push_tail();
        exp_err_q.push_back(1'b0);
        start_job(11'h3C0, 1'b0);
        feed(8'h30, 16, -1);
        wait_done(5);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
